// File: rtl/piso_serialiser.sv
// Parallel-in/serial-out transmitter with a valid/ready load port, a one-deep
// holding buffer for gap-free back-to-back words, per-word bit order, and a
// wrapping completed-word counter. All outputs come straight from registers.
module piso_serialiser #(
    parameter int   N          = 8,
    parameter logic IDLE_LEVEL = 1'b0,
    parameter int   CW         = 8
) (
    input  logic          CLK,
    input  logic          n_Reset,
    input  logic          EN,
    input  logic [N-1:0]  D,
    input  logic          msb_first,
    input  logic          load_valid,
    output logic          load_ready,
    output logic          S,
    output logic          S_valid,
    output logic          S_last,
    output logic          busy,
    output logic [CW-1:0] words_sent
);

    localparam int            BW   = $clog2(N);
    localparam logic [BW-1:0] LAST = BW'(N - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_shift;
    logic           r_msb;
    logic [BW-1:0]  r_cnt;
    logic [N-1:0]   r_hold;
    logic           r_hold_msb;
    logic           r_hold_full;
    logic           r_s;
    logic           r_s_valid;
    logic           r_s_last;
    logic           r_busy;
    logic [CW-1:0]  r_words;

    state_t         w_state_next;
    logic [N-1:0]   w_shift_next;
    logic           w_msb_next;
    logic [BW-1:0]  w_cnt_next;
    logic [N-1:0]   w_hold_next;
    logic           w_hold_msb_next;
    logic           w_hold_full_next;
    logic           w_s_next;
    logic           w_s_valid_next;
    logic           w_s_last_next;
    logic           w_busy_next;
    logic [CW-1:0]  w_words_next;

    logic           w_accept;
    logic           w_load;
    logic [N-1:0]   w_ld_word;
    logic           w_ld_msb;

    // A word can only be taken while the holding buffer is free.
    assign w_accept   = EN & load_valid & ~r_hold_full;
    assign load_ready = ~r_hold_full;

    assign S          = r_s;
    assign S_valid    = r_s_valid;
    assign S_last     = r_s_last;
    assign busy       = r_busy;
    assign words_sent = r_words;

    // State register: asynchronous reset discards any word in flight.
    always_ff @(posedge CLK or negedge n_Reset) begin
        if (!n_Reset) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_msb       <= 1'b0;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_hold_msb  <= 1'b0;
            r_hold_full <= 1'b0;
            r_s         <= IDLE_LEVEL;
            r_s_valid   <= 1'b0;
            r_s_last    <= 1'b0;
            r_busy      <= 1'b0;
            r_words     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_shift     <= w_shift_next;
            r_msb       <= w_msb_next;
            r_cnt       <= w_cnt_next;
            r_hold      <= w_hold_next;
            r_hold_msb  <= w_hold_msb_next;
            r_hold_full <= w_hold_full_next;
            r_s         <= w_s_next;
            r_s_valid   <= w_s_valid_next;
            r_s_last    <= w_s_last_next;
            r_busy      <= w_busy_next;
            r_words     <= w_words_next;
        end
    end

    // Next-state logic: everything holds unless EN is high at the edge.
    always_comb begin
        w_state_next     = r_state;
        w_shift_next     = r_shift;
        w_msb_next       = r_msb;
        w_cnt_next       = r_cnt;
        w_hold_next      = r_hold;
        w_hold_msb_next  = r_hold_msb;
        w_hold_full_next = r_hold_full;
        w_s_next         = r_s;
        w_s_valid_next   = r_s_valid;
        w_s_last_next    = r_s_last;
        w_words_next     = r_words;
        w_load           = 1'b0;
        w_ld_word        = D;
        w_ld_msb         = msb_first;

        if (EN) begin
            case (r_state)
                ST_IDLE: begin
                    // Hold buffer is bypassed when the shifter is free.
                    if (w_accept) begin
                        w_load = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == LAST) begin
                        w_words_next = r_words + 1'b1;
                        if (r_hold_full) begin
                            // Promote the buffered word with no idle gap.
                            w_load           = 1'b1;
                            w_ld_word        = r_hold;
                            w_ld_msb         = r_hold_msb;
                            w_hold_full_next = 1'b0;
                        end else if (w_accept) begin
                            // Arriving word passes through the empty buffer.
                            w_load = 1'b1;
                        end else begin
                            w_state_next   = ST_IDLE;
                            w_s_next       = IDLE_LEVEL;
                            w_s_valid_next = 1'b0;
                            w_s_last_next  = 1'b0;
                        end
                    end else begin
                        w_cnt_next    = r_cnt + 1'b1;
                        w_shift_next  = r_msb ? (r_shift << 1) : (r_shift >> 1);
                        w_s_next      = r_msb ? r_shift[N-2] : r_shift[1];
                        w_s_last_next = ((r_cnt + 1'b1) == LAST);
                        if (w_accept) begin
                            w_hold_next      = D;
                            w_hold_msb_next  = msb_first;
                            w_hold_full_next = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase

            if (w_load) begin
                w_state_next   = ST_SHIFT;
                w_shift_next   = w_ld_word;
                w_msb_next     = w_ld_msb;
                w_cnt_next     = '0;
                w_s_next       = w_ld_msb ? w_ld_word[N-1] : w_ld_word[0];
                w_s_valid_next = 1'b1;
                w_s_last_next  = 1'b0;
            end
        end

        w_busy_next = (w_state_next == ST_SHIFT) | w_hold_full_next;
    end

endmodule
